// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the sequential binary-to-BCD converter.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    localparam int DIGIT_W = 4;
    localparam int ADD3_THRESH = 5;
    localparam logic [DIGIT_W-1:0] BCD_NINE = 4'h9;

endpackage

// File: rtl/bin2bcd_if.sv
// Start/busy/done handshake and result bundle for bin2bcd_seq.
interface bin2bcd_if #(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS = 3
);
    logic                  start;
    logic [IN_WIDTH-1:0]   bin;
    logic                  busy;
    logic                  done;
    logic [4*DIGITS-1:0]   bcd;
    logic                  overflow;
    logic [DIGITS-1:0]     blank;

    modport master (
        output start, bin,
        input  busy, done, bcd, overflow, blank
    );

    modport slave (
        input  start, bin,
        output busy, done, bcd, overflow, blank
    );
endinterface

// File: rtl/bin2bcd_seq_bcd_digit_adj.sv
// Double-dabble digit correction: a BCD digit of 5 or more gets +3
// so the following left shift carries cleanly into the next decade.
module bcd_digit_adj
    import bin2bcd_pkg::*;
(
    input  logic [DIGIT_W-1:0] din,
    output logic [DIGIT_W-1:0] dout
);
    assign dout = (din >= DIGIT_W'(ADD3_THRESH))
                ? din + DIGIT_W'(3)
                : din;
endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential double-dabble converter, one input bit per clock.
// Optional leading-zero blanking mask: define BIN2BCD_LZB_EN.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int IN_WIDTH = 8,
    parameter int DIGITS = 3
) (
    input  logic  clk,
    input  logic  reset,
    bin2bcd_if.slave bus
);
    localparam int BCD_W = DIGIT_W * DIGITS;
    localparam int CNT_W = $clog2(IN_WIDTH + 1);
    localparam int TOP = BCD_W + IN_WIDTH;
    localparam logic [BCD_W-1:0] ALL_NINES = {DIGITS{BCD_NINE}};

    state_t              state;
    logic [IN_WIDTH-1:0] bin_q;
    logic [BCD_W-1:0]    scratch;
    logic [BCD_W-1:0]    adj;
    logic                ovf_q;
    logic [CNT_W-1:0]    cnt;
    logic                busy_q;
    logic                done_q;
    logic [BCD_W-1:0]    bcd_q;
    logic                ovf_out_q;
    logic [TOP:0]        shifted;

    for (genvar g = 0; g < DIGITS; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .din  (scratch[g*DIGIT_W +: DIGIT_W]),
            .dout (adj[g*DIGIT_W +: DIGIT_W])
        );
    end

    // Bit TOP is the carry out of the highest decade.
    assign shifted = {adj, bin_q, 1'b0};

`ifdef BIN2BCD_LZB_EN
    logic [DIGITS-1:0] blank_next;
    logic [DIGITS-1:0] blank_q;

    always_comb begin : lzb
        logic run;
        blank_next = '0;
        run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            run = run && (scratch[i*DIGIT_W +: DIGIT_W] == '0);
            blank_next[i] = run;
        end
        if (ovf_q) begin
            blank_next = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            blank_q <= '0;
        end else if (state == DONE) begin
            blank_q <= blank_next;
        end
    end

    assign bus.blank = blank_q;
`else
    assign bus.blank = '0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            bin_q     <= '0;
            scratch   <= '0;
            ovf_q     <= 1'b0;
            cnt       <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            bcd_q     <= '0;
            ovf_out_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        bin_q   <= bus.bin;
                        scratch <= '0;
                        ovf_q   <= 1'b0;
                        cnt     <= CNT_W'(IN_WIDTH);
                        busy_q  <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= shifted[TOP-1 -: BCD_W];
                    bin_q   <= shifted[IN_WIDTH-1:0];
                    ovf_q   <= ovf_q | shifted[TOP];
                    cnt     <= cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        busy_q <= 1'b0;
                        state  <= DONE;
                    end
                end
                DONE: begin
                    bcd_q     <= ovf_q ? ALL_NINES : scratch;
                    ovf_out_q <= ovf_q;
                    done_q    <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy     = busy_q;
    assign bus.done     = done_q;
    assign bus.bcd      = bcd_q;
    assign bus.overflow = ovf_out_q;
endmodule

// File: tb/tb_bin2bcd_seq.sv
// Bench for bin2bcd_seq: 3-digit and 2-digit instances driven in
// parallel, results compared against a decimal arithmetic model.
module tb_bin2bcd_seq;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       start = 1'b0;
    logic [7:0] bin = '0;

    int errors = 0;
    int checks = 0;

    int done_at;
    int busy_n;
    int n_done;
    bit clash;

    bin2bcd_if #(.IN_WIDTH(8), .DIGITS(3)) if3 ();
    bin2bcd_if #(.IN_WIDTH(8), .DIGITS(2)) if2 ();

    assign if3.start = start;
    assign if3.bin   = bin;
    assign if2.start = start;
    assign if2.bin   = bin;

    bin2bcd_seq #(.IN_WIDTH(8), .DIGITS(3)) dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    bin2bcd_seq #(.IN_WIDTH(8), .DIGITS(2)) dut2 (
        .clk   (clk),
        .reset (reset),
        .bus   (if2)
    );

    always #5 clk = ~clk;

    task automatic check(string tag, logic [31:0] got,
                         logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int pow10(int n);
        int r = 1;
        for (int i = 0; i < n; i++) r = r * 10;
        return r;
    endfunction

    function automatic logic [31:0] ref_bcd(int v, int d);
        logic [31:0] r = '0;
        if (v >= pow10(d)) begin
            for (int i = 0; i < d; i++) r = r | (32'h9 << (4 * i));
        end else begin
            for (int i = 0; i < d; i++) begin
                r = r | (32'(v % 10) << (4 * i));
                v = v / 10;
            end
        end
        return r;
    endfunction

    function automatic logic [31:0] ref_ovf(int v, int d);
        return (v >= pow10(d)) ? 32'd1 : 32'd0;
    endfunction

    function automatic logic [31:0] ref_blank(int v, int d);
        logic [31:0] r = '0;
`ifdef BIN2BCD_LZB_EN
        if (v < pow10(d)) begin
            for (int i = 1; i < d; i++) begin
                if (v < pow10(i)) r[i] = 1'b1;
            end
        end
`endif
        return r;
    endfunction

    task automatic launch(int v);
        @(negedge clk);
        bin = 8'(v);
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
    endtask

    task automatic watch(int limit, bit stop, int poke_a,
                         int poke_b, int poke_bin);
        done_at = -1;
        busy_n = 0;
        n_done = 0;
        clash = 1'b0;
        for (int i = 0; i < limit; i++) begin
            if (if3.busy) busy_n++;
            if (if3.done || if2.done) begin
                n_done++;
                if (done_at < 0) done_at = i;
            end
            if ((if3.done && if3.busy) || (if2.done && if2.busy))
                clash = 1'b1;
            if (stop && if3.done) break;
            if (i == poke_a || i == poke_b) begin
                start = 1'b1;
                bin = 8'(poke_bin);
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
        end
        start = 1'b0;
    endtask

    task automatic result_check(string tag, int v);
        check({tag, "_bcd3"}, 32'(if3.bcd), ref_bcd(v, 3));
        check({tag, "_ovf3"}, 32'(if3.overflow), ref_ovf(v, 3));
        check({tag, "_blank3"}, 32'(if3.blank), ref_blank(v, 3));
        check({tag, "_bcd2"}, 32'(if2.bcd), ref_bcd(v, 2));
        check({tag, "_ovf2"}, 32'(if2.overflow), ref_ovf(v, 2));
        check({tag, "_blank2"}, 32'(if2.blank), ref_blank(v, 2));
    endtask

    task automatic convert(string tag, int v);
        launch(v);
        watch(20, 1'b1, -1, -1, 0);
        check({tag, "_latency"}, 32'(done_at), 32'd9);
        check({tag, "_busy_cycles"}, 32'(busy_n), 32'd8);
        check({tag, "_done_busy"}, 32'(clash), 32'd0);
        result_check(tag, v);
    endtask

    initial begin
        int v;
        int gap;

        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", 32'(if3.busy), 32'd0);
        check("rst_done", 32'(if3.done), 32'd0);
        check("rst_bcd", 32'(if3.bcd), 32'd0);
        check("rst_ovf", 32'(if3.overflow), 32'd0);
        check("rst_blank", 32'(if3.blank), 32'd0);
        check("rst_bcd2", 32'(if2.bcd), 32'd0);
        reset = 1'b1;

        convert("v255", 255);
        convert("v7", 7);
        convert("v0", 0);
        convert("v100", 100);
        convert("v42", 42);

        // Retrigger mid-conversion (ignored) and on the done cycle.
        launch(128);
        watch(14, 1'b0, 3, 9, 55);
        check("retrig_ndone", 32'(n_done), 32'd1);
        check("retrig_latency", 32'(done_at), 32'd9);
        result_check("retrig", 128);
        watch(20, 1'b1, -1, -1, 0);
        check("retrig2_seen", 32'(done_at >= 0), 32'd1);
        result_check("retrig2", 55);

        // Reset while shifting abandons the conversion.
        launch(200);
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b1;
        check("abort_busy", 32'(if3.busy), 32'd0);
        check("abort_done", 32'(if3.done), 32'd0);
        check("abort_bcd", 32'(if3.bcd), 32'd0);
        check("abort_ovf2", 32'(if2.overflow), 32'd0);
        watch(15, 1'b0, -1, -1, 0);
        check("abort_ndone", 32'(n_done), 32'd0);
        convert("v19", 19);

        repeat (30) begin
            v = int'($urandom_range(0, 255));
            gap = int'($urandom_range(0, 3));
            repeat (gap) @(posedge clk);
            convert("rand", v);
        end

        for (int k = 0; k < 256; k++) begin
            convert("sweep", k);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
